// File: rtl/multi_cycle_controller_if.sv
// Control bundle between the multi-cycle controller (master) and the MIPS data path (slave).
interface multi_cycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       func;
  logic             ZERO;
  logic             mem_ready;
  logic             reg_dst;
  logic             jal_reg;
  logic             pc_to_reg;
  logic             alu_src;
  logic             mem_to_reg;
  logic             jump_sel;
  logic             pc_jump;
  logic             pc_src;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic [2:0]       alu_cntrl;
  logic             pc_en;
  logic             illegal;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, func, ZERO, mem_ready,
    output reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
    output jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write,
    output alu_cntrl, pc_en, illegal, state, instr_count
  );

  modport slave (
    output opcode, func, ZERO, mem_ready,
    input  reg_dst, jal_reg, pc_to_reg, alu_src, mem_to_reg,
    input  jump_sel, pc_jump, pc_src, reg_write, mem_read, mem_write,
    input  alu_cntrl, pc_en, illegal, state, instr_count
  );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB, sticky TRAP).
// Optional retired-instruction counter enabled by defining PERF_CNT_EN.
module multi_cycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multi_cycle_controller_if.master bus
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_JR    = 6'b001000;

  state_t     r_state;
  logic       r_illegal;
  logic [2:0] w_r_alu;
  logic       w_func_ok;
  logic       w_legal;
  logic       w_is_jr;
  logic       w_short;
  logic       w_is_mem;
  logic       w_reg_dst, w_jal_reg, w_pc_to_reg, w_alu_src, w_mem_to_reg;
  logic       w_jump_sel, w_pc_jump, w_pc_src;
  logic       w_reg_write, w_mem_read, w_mem_write, w_pc_en;
  logic [2:0] w_alu_cntrl;

  // R-type function decode: ALU operation and legality of func
  always_comb begin
    w_r_alu   = 3'b000;
    w_func_ok = 1'b1;
    case (bus.func)
      F_ADD:   w_r_alu = 3'b010;
      F_SUB:   w_r_alu = 3'b110;
      F_AND:   w_r_alu = 3'b000;
      F_OR:    w_r_alu = 3'b001;
      F_SLT:   w_r_alu = 3'b111;
      F_JR:    w_r_alu = 3'b000;
      default: w_func_ok = 1'b0;
    endcase
  end

  // Opcode legality check consulted in DECODE
  always_comb begin
    case (bus.opcode)
      OP_R:                                          w_legal = w_func_ok;
      OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: w_legal = 1'b1;
      default:                                       w_legal = 1'b0;
    endcase
  end

  assign w_is_jr  = (bus.opcode == OP_R) && (bus.func == F_JR);
  // Control-flow instructions retire straight out of EXEC.
  assign w_short  = (bus.opcode == OP_J) || (bus.opcode == OP_JAL) ||
                    (bus.opcode == OP_BEQ) || w_is_jr;
  assign w_is_mem = (bus.opcode == OP_LW) || (bus.opcode == OP_SW);

  // State sequencing and sticky trap flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_short)       r_state <= S_FETCH;
          else if (w_is_mem) r_state <= S_MEM;
          else               r_state <= S_WB;
        end
        S_MEM: begin
          if (bus.mem_ready) r_state <= (bus.opcode == OP_LW) ? S_WB : S_FETCH;
          else               r_state <= S_MEM;
        end
        S_WB:    r_state <= S_FETCH;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // Control outputs decoded from the current state and the held instruction
  always_comb begin
    w_reg_dst   = 1'b0;
    w_jal_reg   = 1'b0;
    w_pc_to_reg = 1'b0;
    w_alu_src   = 1'b0;
    w_mem_to_reg = 1'b0;
    w_jump_sel  = 1'b0;
    w_pc_jump   = 1'b0;
    w_pc_src    = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pc_en     = 1'b0;
    w_alu_cntrl = 3'b000;
    case (r_state)
      S_EXEC: begin
        case (bus.opcode)
          OP_R: begin
            if (w_is_jr) begin
              w_pc_jump = 1'b1;
              w_pc_en   = 1'b1;
            end else begin
              w_alu_cntrl = w_r_alu;
            end
          end
          OP_ADDI, OP_LW, OP_SW: begin
            w_alu_src   = 1'b1;
            w_alu_cntrl = 3'b010;
          end
          OP_SLTI: begin
            w_alu_src   = 1'b1;
            w_alu_cntrl = 3'b111;
          end
          OP_BEQ: begin
            w_alu_cntrl = 3'b110;
            w_pc_src    = bus.ZERO;
            w_pc_en     = 1'b1;
          end
          OP_J, OP_JAL: begin
            w_jump_sel  = 1'b1;
            w_pc_jump   = 1'b1;
            w_pc_en     = 1'b1;
            w_jal_reg   = (bus.opcode == OP_JAL);
            w_pc_to_reg = (bus.opcode == OP_JAL);
            w_reg_write = (bus.opcode == OP_JAL);
          end
          default: w_pc_en = 1'b0;
        endcase
      end
      S_MEM: begin
        // A store retires in the cycle memory accepts it.
        if (bus.opcode == OP_SW) begin
          w_mem_write = 1'b1;
          w_pc_en     = bus.mem_ready;
        end else begin
          w_mem_read  = 1'b1;
        end
      end
      S_WB: begin
        w_reg_write  = 1'b1;
        w_pc_en      = 1'b1;
        w_reg_dst    = (bus.opcode == OP_R);
        w_mem_to_reg = (bus.opcode == OP_LW);
      end
      default: w_pc_en = 1'b0;
    endcase
  end

  assign bus.reg_dst    = w_reg_dst;
  assign bus.jal_reg    = w_jal_reg;
  assign bus.pc_to_reg  = w_pc_to_reg;
  assign bus.alu_src    = w_alu_src;
  assign bus.mem_to_reg = w_mem_to_reg;
  assign bus.jump_sel   = w_jump_sel;
  assign bus.pc_jump    = w_pc_jump;
  assign bus.pc_src     = w_pc_src;
  assign bus.reg_write  = w_reg_write;
  assign bus.mem_read   = w_mem_read;
  assign bus.mem_write  = w_mem_write;
  assign bus.pc_en      = w_pc_en;
  assign bus.alu_cntrl  = w_alu_cntrl;
  assign bus.illegal    = r_illegal;
  assign bus.state      = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_count;

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_pc_en) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign bus.instr_count = r_count;
`else
  assign bus.instr_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: vector table, random instructions vs. a
// latency/retire-signature model, and hand sequences for reset, stalls, trap and counter.
module tb_multi_cycle_controller;
  localparam int TB_CNT_W = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_JR = 6'b001000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   retired = 0;

  multi_cycle_controller_if #(.CNT_W(TB_CNT_W)) bus ();
  multi_cycle_controller #(.CNT_W(TB_CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // retire signature bits: rw rd m2r jal_reg p2r jump_sel pc_jump pc_src mem_write mem_read
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         lat;
    logic [9:0] sig;
    logic [2:0] alu;
    logic       asrc;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: latency and retire-cycle signature derived from the instruction rules.
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int stalls, output int lat, output logic [9:0] sig,
                                output logic [2:0] alu, output logic asrc, output int mcyc);
    lat = 0; sig = 10'b0; alu = 3'b000; asrc = 1'b0; mcyc = 0;
    case (op)
      OP_R: begin
        if (fn == F_JR) begin
          lat = 3; sig[3] = 1'b1;
        end else begin
          lat = 4; sig[9] = 1'b1; sig[8] = 1'b1;
          alu = (fn == F_ADD) ? 3'b010 : (fn == F_SUB) ? 3'b110 :
                (fn == F_AND) ? 3'b000 : (fn == F_OR) ? 3'b001 : 3'b111;
        end
      end
      OP_ADDI: begin lat = 4; sig[9] = 1'b1; alu = 3'b010; asrc = 1'b1; end
      OP_SLTI: begin lat = 4; sig[9] = 1'b1; alu = 3'b111; asrc = 1'b1; end
      OP_LW: begin
        lat = 5 + stalls; sig[9] = 1'b1; sig[7] = 1'b1; alu = 3'b010; asrc = 1'b1;
        mcyc = stalls + 1;
      end
      OP_SW: begin
        lat = 4 + stalls; sig[1] = 1'b1; alu = 3'b010; asrc = 1'b1; mcyc = stalls + 1;
      end
      OP_BEQ: begin lat = 3; sig[2] = z; alu = 3'b110; end
      OP_J:   begin lat = 3; sig[4] = 1'b1; sig[3] = 1'b1; end
      OP_JAL: begin lat = 3; sig[9] = 1'b1; sig[6:3] = 4'b1111; end
      default: lat = 0;
    endcase
  endfunction

  // Runs one instruction from the start of FETCH until its pc_en cycle (bounded).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int stalls, output int lat, output logic [9:0] sig,
                           output int rw, output int mr, output int mw,
                           output logic [2:0] alu3, output logic asrc3,
                           output logic [2:0] st1, output logic [2:0] st2);
    logic lw_sw;
    lw_sw = (op == OP_LW) || (op == OP_SW);
    bus.opcode = op; bus.func = fn; bus.ZERO = z;
    lat = 0; sig = 10'b0; rw = 0; mr = 0; mw = 0;
    alu3 = 3'b000; asrc3 = 1'b0; st1 = 3'b000; st2 = 3'b000;
    for (int c = 1; c <= 30; c++) begin
      if (lw_sw && c >= 4) bus.mem_ready = (c >= 4 + stalls);
      else                 bus.mem_ready = 1'($urandom_range(0, 1));
      #3;
      if (c == 1) st1 = bus.state;
      if (c == 2) st2 = bus.state;
      if (c == 3) begin alu3 = bus.alu_cntrl; asrc3 = bus.alu_src; end
      rw += int'(bus.reg_write);
      mr += int'(bus.mem_read);
      mw += int'(bus.mem_write);
      if (bus.pc_en) begin
        lat = c;
        sig = {bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.jal_reg, bus.pc_to_reg,
               bus.jump_sel, bus.pc_jump, bus.pc_src, bus.mem_write, bus.mem_read};
      end
      @(posedge clk); #1;
      if (lat != 0) break;
    end
    if (lat != 0) retired++;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    retired = 0;
  endtask

  task automatic check_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stalls);
    int lat, rw, mr, mw, e_lat, e_m;
    logic [9:0] sig, e_sig;
    logic [2:0] alu3, e_alu, st1, st2;
    logic asrc3, e_asrc;
    model(op, fn, z, stalls, e_lat, e_sig, e_alu, e_asrc, e_m);
    run_instr(op, fn, z, stalls, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
    chk({tag, " latency"}, 64'(lat), 64'(e_lat));
    chk({tag, " retire_sig"}, 64'(sig), 64'(e_sig));
    chk({tag, " reg_write_cycles"}, 64'(rw), 64'(e_sig[9]));
    chk({tag, " mem_read_cycles"}, 64'(mr), 64'((op == OP_LW) ? e_m : 0));
    chk({tag, " mem_write_cycles"}, 64'(mw), 64'((op == OP_SW) ? e_m : 0));
    chk({tag, " exec_alu"}, 64'(alu3), 64'(e_alu));
    chk({tag, " exec_alu_src"}, 64'(asrc3), 64'(e_asrc));
  endtask

  initial begin
    int lat, rw, mr, mw, pc_cnt;
    logic [9:0] sig;
    logic [2:0] alu3, st1, st2;
    logic asrc3;

    vecs[0]  = '{OP_R,    F_ADD, 1'b0, 4, 10'b1100000000, 3'b010, 1'b0};
    vecs[1]  = '{OP_R,    F_SUB, 1'b0, 4, 10'b1100000000, 3'b110, 1'b0};
    vecs[2]  = '{OP_R,    F_AND, 1'b1, 4, 10'b1100000000, 3'b000, 1'b0};
    vecs[3]  = '{OP_R,    F_OR,  1'b0, 4, 10'b1100000000, 3'b001, 1'b0};
    vecs[4]  = '{OP_R,    F_SLT, 1'b0, 4, 10'b1100000000, 3'b111, 1'b0};
    vecs[5]  = '{OP_R,    F_JR,  1'b0, 3, 10'b0000001000, 3'b000, 1'b0};
    vecs[6]  = '{OP_ADDI, 6'd5,  1'b0, 4, 10'b1000000000, 3'b010, 1'b1};
    vecs[7]  = '{OP_SLTI, 6'd9,  1'b0, 4, 10'b1000000000, 3'b111, 1'b1};
    vecs[8]  = '{OP_LW,   6'd0,  1'b0, 5, 10'b1010000000, 3'b010, 1'b1};
    vecs[9]  = '{OP_SW,   6'd0,  1'b0, 4, 10'b0000000010, 3'b010, 1'b1};
    vecs[10] = '{OP_BEQ,  6'd0,  1'b1, 3, 10'b0000000100, 3'b110, 1'b0};
    vecs[11] = '{OP_BEQ,  6'd0,  1'b0, 3, 10'b0000000000, 3'b110, 1'b0};
    vecs[12] = '{OP_J,    6'd0,  1'b0, 3, 10'b0000011000, 3'b000, 1'b0};
    vecs[13] = '{OP_JAL,  6'd0,  1'b0, 3, 10'b1001111000, 3'b000, 1'b0};

    bus.opcode = OP_R; bus.func = F_ADD; bus.ZERO = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("reset state", 64'(bus.state), 64'd0);
    chk("reset outputs", 64'({bus.pc_en, bus.reg_write, bus.mem_write, bus.mem_read,
                              bus.illegal, bus.alu_cntrl}), 64'd0);
    chk("reset count", 64'(bus.instr_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fn, vecs[i].z, 0, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d retire_sig", i), 64'(sig), 64'(vecs[i].sig));
      chk($sformatf("vec%0d reg_write_cycles", i), 64'(rw), 64'(vecs[i].sig[9]));
      chk($sformatf("vec%0d exec_alu", i), 64'(alu3), 64'(vecs[i].alu));
      chk($sformatf("vec%0d exec_alu_src", i), 64'(asrc3), 64'(vecs[i].asrc));
      chk($sformatf("vec%0d fetch_decode_states", i), 64'({st1, st2}), 64'({3'd0, 3'd1}));
    end

    run_instr(OP_LW, 6'd0, 1'b0, 3, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
    chk("lw_stall latency", 64'(lat), 64'd8);
    chk("lw_stall mem_read_cycles", 64'(mr), 64'd4);
    chk("lw_stall retire_sig", 64'(sig), 64'(10'b1010000000));
    run_instr(OP_SW, 6'd0, 1'b0, 2, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
    chk("sw_stall latency", 64'(lat), 64'd6);
    chk("sw_stall mem_write_cycles", 64'(mw), 64'd3);

    for (int n = 0; n < 200; n++) begin
      int k, st;
      k  = $urandom_range(0, 13);
      st = ((vecs[k].op == OP_LW) || (vecs[k].op == OP_SW)) ? $urandom_range(0, 3) : 0;
      check_instr($sformatf("rand%0d", n), vecs[k].op, vecs[k].fn, 1'($urandom_range(0, 1)), st);
    end

`ifdef PERF_CNT_EN
    chk("count after random", 64'(bus.instr_count), 64'(retired % 16));
    do_reset();
    for (int n = 0; n < 10; n++)
      run_instr(OP_R, F_ADD, 1'b0, 0, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
    chk("count 10 adds", 64'(bus.instr_count), 64'd10);
    for (int n = 0; n < 6; n++)
      run_instr(OP_R, F_ADD, 1'b0, 0, lat, sig, rw, mr, mw, alu3, asrc3, st1, st2);
    chk("count wrap 16", 64'(bus.instr_count), 64'd0);
`else
    chk("count tied zero", 64'(bus.instr_count), 64'd0);
`endif

    // reset asserted mid-EXEC of add
    bus.opcode = OP_R; bus.func = F_ADD; bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    chk("rst_exec state", 64'(bus.state), 64'd0);
    chk("rst_exec strobes", 64'({bus.reg_write, bus.pc_en, bus.illegal}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // reset asserted during WB drops the write strobe at once
    repeat (3) begin @(posedge clk); #1; end
    chk("wb reg_write before reset", 64'(bus.reg_write), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_wb strobes", 64'({bus.reg_write, bus.pc_en, bus.state}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // undefined opcode -> sticky trap
    bus.opcode = 6'b111111; bus.func = 6'd0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    chk("trap state", 64'(bus.state), 64'd7);
    chk("trap illegal", 64'(bus.illegal), 64'd1);
    bus.opcode = OP_R; bus.func = F_ADD;
    pc_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #3;
      pc_cnt += int'(bus.pc_en) + int'(bus.reg_write) + int'(bus.mem_write);
    end
    chk("trap no strobes 20 cycles", 64'(pc_cnt), 64'd0);
    chk("trap sticky", 64'({bus.illegal, bus.state}), 64'({1'b1, 3'd7}));
    do_reset();
    #3;
    chk("trap cleared by reset", 64'({bus.illegal, bus.state}), 64'd0);
    chk("count cleared by reset", 64'(bus.instr_count), 64'd0);
    #(-3 + 3);
    @(posedge clk); #1;
    do_reset();

    // undefined R-type func also traps
    bus.opcode = OP_R; bus.func = 6'b111111;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    chk("bad func trap", 64'({bus.illegal, bus.state}), 64'({1'b1, 3'd7}));
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
